// File: rtl/perceptron_seq.sv
// Sequencer for a single perceptron: clears the accumulator, steps the MAC over all inputs plus
// bias, thresholds the sum and optionally walks the weight-update pass on a misclassification.
module perceptron_seq #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = $clog2(N_INPUTS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             train_i,
  input  logic             target_i,
  input  logic             sum_sign_i,
  input  logic             clr_cnt_i,
  output logic             busy_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             acc_clr_o,
  output logic             mac_en_o,
  output logic             wt_we_o,
  output logic             upd_dir_o,
  output logic             y_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StAct,
    StUpdate,
    StDone
  } state_e;

  // Index N_INPUTS addresses the bias weight (implied input of 1).
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_INPUTS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             train_q, train_d;
  logic             tgt_q, tgt_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_inc;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      train_q <= 1'b0;
      tgt_q   <= 1'b0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      train_q <= train_d;
      tgt_q   <= tgt_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    train_d = train_q;
    tgt_d   = tgt_q;
    y_d     = y_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StClear;
          train_d = train_i;
          tgt_d   = target_i;
        end
      end
      StClear: begin
        idx_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StAct;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StAct: begin
        // Sign bit clear means sum >= 0, i.e. positive class.
        y_d = ~sum_sign_i;
        if (train_q && (~sum_sign_i != tgt_q)) begin
          state_d = StUpdate;
          cnt_inc = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StUpdate: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Clear wins over a same-cycle increment; the counter saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign idx_o     = idx_q;
  assign acc_clr_o = (state_q == StClear);
  assign mac_en_o  = (state_q == StMac);
  assign wt_we_o   = (state_q == StUpdate);
  assign upd_dir_o = (state_q == StUpdate) && tgt_q;
  assign done_o    = (state_q == StDone);
  assign y_o       = y_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_perceptron_seq.sv
// Scoreboard bench for perceptron_seq: stimulus pushes per-pass expectations, a negedge monitor
// checks pass shape and results whenever done_o is presented.
module tb_perceptron_seq;

  localparam int unsigned N      = 4;
  localparam int unsigned CW     = 2;
  localparam int unsigned IW     = $clog2(N + 1);
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic          clk_i      = 1'b0;
  logic          reset_ni   = 1'b0;
  logic          start_i    = 1'b0;
  logic          train_i    = 1'b0;
  logic          target_i   = 1'b0;
  logic          sum_sign_i = 1'b0;
  logic          clr_cnt_i  = 1'b0;
  logic          busy_o;
  logic [IW-1:0] idx_o;
  logic          acc_clr_o;
  logic          mac_en_o;
  logic          wt_we_o;
  logic          upd_dir_o;
  logic          y_o;
  logic          done_o;
  logic [CW-1:0] err_cnt_o;

  perceptron_seq #(
    .N_INPUTS(N),
    .CNT_W   (CW)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .start_i   (start_i),
    .train_i   (train_i),
    .target_i  (target_i),
    .sum_sign_i(sum_sign_i),
    .clr_cnt_i (clr_cnt_i),
    .busy_o    (busy_o),
    .idx_o     (idx_o),
    .acc_clr_o (acc_clr_o),
    .mac_en_o  (mac_en_o),
    .wt_we_o   (wt_we_o),
    .upd_dir_o (upd_dir_o),
    .y_o       (y_o),
    .done_o    (done_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          y;
    bit          upd;
    bit          dir;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned m_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called in cycle 0 (IDLE, start accepted at the coming edge); returns in the first idle cycle.
  task automatic run_pass(input bit tr, input bit tg, input bit sg, input bit clr_inc);
    bit   mis;
    exp_t e;
    int   len;
    mis = tr && ((!sg) != tg);
    if (clr_inc) m_cnt = 0;
    else if (mis && m_cnt < CntMax) m_cnt++;
    e.y = !sg; e.upd = mis; e.dir = tg; e.cnt = m_cnt;
    sb.push_back(e);
    len = mis ? 2 * N + 5 : N + 4;
    start_i = 1'b1; train_i = tr; target_i = tg; sum_sign_i = 1'($urandom); clr_cnt_i = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk_i);
      start_i    = (c == 3 || c == len) ? 1'b1 : 1'($urandom);
      train_i    = 1'($urandom);
      target_i   = 1'($urandom);
      sum_sign_i = (c == N + 3) ? sg : 1'($urandom);
      clr_cnt_i  = (c == N + 3) && clr_inc;
    end
    @(negedge clk_i);
    start_i   = 1'b0;
    clr_cnt_i = 1'b0;
  endtask

  task automatic reset_mid_pass();
    start_i = 1'b1; train_i = 1'b1; target_i = 1'b1; sum_sign_i = 1'b0; clr_cnt_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      start_i    = 1'b0;
      train_i    = 1'($urandom);
      target_i   = 1'($urandom);
      sum_sign_i = (c == N + 3) ? 1'b1 : 1'($urandom);
    end
    #2 reset_ni = 1'b0;
    #1 check("reset_async", {busy_o, idx_o, acc_clr_o, mac_en_o, wt_we_o, upd_dir_o, done_o,
                             y_o, err_cnt_o}, '0);
    m_cnt = 0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  // Monitor: tracks the shape of each pass and compares against the scoreboard at done_o.
  int unsigned cyc = 0, acc_cyc = 0, mac_n = 0, we_n = 0;
  bit          mac_bad = 0, we_bad = 0, we_dir = 0, prev_done = 0, last_y = 0;

  always @(negedge clk_i) begin
    exp_t e;
    bit   ok;
    if (!reset_ni) begin
      cyc = 0; prev_done = 0; last_y = 0;
    end else begin
      ok = $onehot0({acc_clr_o, mac_en_o, wt_we_o, done_o})
           && (mac_en_o || wt_we_o || idx_o == '0)
           && (wt_we_o || !upd_dir_o)
           && (busy_o || !(acc_clr_o || mac_en_o || wt_we_o || done_o));
      n_checks++;
      if (!ok) begin
        n_err++;
        $display("FAIL strobes: got busy=%b idx=%0d clr=%b mac=%b we=%b dir=%b done=%b at %0t",
                 busy_o, idx_o, acc_clr_o, mac_en_o, wt_we_o, upd_dir_o, done_o, $time);
      end
      cyc = busy_o ? cyc + 1 : 0;
      if (cyc == 1) begin
        acc_cyc = 0; mac_n = 0; we_n = 0; mac_bad = 0; we_bad = 0;
      end
      if (acc_clr_o) acc_cyc = cyc;
      if (mac_en_o) begin
        if (idx_o != IW'(mac_n) || cyc != 2 + mac_n) mac_bad = 1;
        mac_n++;
      end
      if (wt_we_o) begin
        if (idx_o != IW'(we_n) || cyc != N + 4 + we_n) we_bad = 1;
        if (we_n == 0) we_dir = upd_dir_o;
        else if (upd_dir_o != we_dir) we_bad = 1;
        we_n++;
      end
      if (prev_done) check("idle_after_done", busy_o, 0);
      if (!busy_o) check("y_hold", y_o, last_y);
      if (done_o) begin
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_done: got done_o=1 expected no pass pending at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.upd ? 2 * N + 5 : N + 4);
          check("acc_clr_cycle", acc_cyc, 1);
          check("mac_count", mac_n, N + 1);
          check("mac_seq_bad", mac_bad, 0);
          check("we_count", we_n, e.upd ? N + 1 : 0);
          check("we_seq_bad", we_bad, 0);
          if (e.upd) check("upd_dir", we_dir, e.dir);
          check("y", y_o, e.y);
          check("err_cnt", err_cnt_o, e.cnt);
          last_y = e.y;
        end
      end
      prev_done = done_o;
    end
  end

  initial begin
    repeat (2) @(negedge clk_i);
    check("reset_state", {busy_o, idx_o, acc_clr_o, mac_en_o, wt_we_o, upd_dir_o, done_o,
                          y_o, err_cnt_o}, '0);
    reset_ni = 1'b1;
    run_pass(1'b0, 1'b0, 1'b0, 1'b0);   // inference, accepted on first edge after reset
    run_pass(1'b1, 1'b1, 1'b1, 1'b0);   // training miss -> cnt 1
    run_pass(1'b1, 1'b0, 1'b1, 1'b0);   // training hit
    repeat (3) run_pass(1'b1, 1'b0, 1'b0, 1'b0);  // cnt 2, 3, 3 (saturated)
    run_pass(1'b1, 1'b1, 1'b1, 1'b1);   // clear on the increment cycle -> 0
    run_pass(1'b1, 1'b1, 1'b1, 1'b0);
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      run_pass(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    run_pass(1'b1, 1'b1, 1'b1, 1'b0);
    reset_mid_pass();
    run_pass(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/perceptron_seq.md
PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

Interface
REQ-001 Parameter N_INPUTS, default 4: number of perceptron inputs; the bias is handled as weight index N_INPUTS with an implied input of 1; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the misclassification counter.
REQ-003 Local IDX_W SHALL be $clog2(N_INPUTS+1).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  request one evaluation; sampled only in IDLE.
REQ-007 train_i  input  1  request a weight update on misclassification; captured with start_i.
REQ-008 target_i  input  1  expected class (1 = positive); captured with start_i.
REQ-009 sum_sign_i  input  1  datapath accumulator sign (1 = negative); sampled only in ACT.
REQ-010 clr_cnt_i  input  1  synchronous clear of err_cnt_o.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 idx_o  output  IDX_W  input/weight address presented to the datapath.
REQ-013 acc_clr_o  output  1  clear the datapath accumulator.
REQ-014 mac_en_o  output  1  accumulate x[idx_o]*w[idx_o].
REQ-015 wt_we_o  output  1  write the updated weight at idx_o.
REQ-016 upd_dir_o  output  1  update direction: 1 = w += x, 0 = w -= x.
REQ-017 y_o  output  1  registered classification result.
REQ-018 done_o  output  1  one-cycle completion pulse.
REQ-019 err_cnt_o  output  CNT_W  count of misclassifications seen in training passes.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, MAC, ACT, UPDATE, DONE, with registered state and Moore outputs.
REQ-021 IDLE -> CLEAR when start_i=1; train_i and target_i are latched into train_q and tgt_q on the same edge.
REQ-022 CLEAR SHALL last 1 cycle, with acc_clr_o=1, idx_o=0 -> MAC.
REQ-023 MAC SHALL last N_INPUTS+1 cycles, with mac_en_o=1 and idx_o stepping 0,1,...,N_INPUTS, one step per cycle -> ACT after idx N_INPUTS.
REQ-024 ACT SHALL last 1 cycle; at its end, y_o <= ~sum_sign_i (so sum >= 0 gives 1).
REQ-025 ACT -> UPDATE if train_q=1 and ~sum_sign_i != tgt_q; otherwise ACT -> DONE.
REQ-026 UPDATE SHALL last N_INPUTS+1 cycles, with wt_we_o=1, upd_dir_o=tgt_q and idx_o stepping 0..N_INPUTS -> DONE.
REQ-027 On the ACT->UPDATE transition, err_cnt_o SHALL increment by 1 and saturate at all-ones.
REQ-028 DONE SHALL last 1 cycle with done_o=1 -> IDLE.
REQ-029 Timing, with the accepting edge taken as cycle 0:
- done_o is high in cycle N_INPUTS+4 with no update.
- done_o is high in cycle 2*N_INPUTS+5 with an update.
REQ-030 start_i SHALL be ignored while busy_o=1; it is not queued, and start_i held high restarts only after IDLE.
REQ-031 acc_clr_o, mac_en_o, wt_we_o and done_o SHALL be mutually exclusive and 0 outside their states.
REQ-032 idx_o SHALL be 0 in IDLE, ACT and DONE.
REQ-033 upd_dir_o SHALL be 0 outside UPDATE.
REQ-034 clr_cnt_i SHALL have priority over an increment in the same cycle; the result is 0.
REQ-035 y_o SHALL hold its value until the next ACT.
REQ-036 Inputs sum_sign_i, train_i and target_i SHALL be ignored outside their sampling points.

Reset
REQ-037 When reset_ni=0, all of the following SHALL be forced asynchronously: state=IDLE, idx_o=0, y_o=0, err_cnt_o=0, train_q=0, tgt_q=0, and every strobe output 0.
REQ-038 Reset asserted mid-pass (MAC or UPDATE) SHALL abort immediately:
- no further wt_we_o;
- no done_o;
- after release, the block waits in IDLE for a new start_i.
REQ-039 Outputs SHALL be valid from the first edge after reset_ni deasserts; a start_i on that edge is accepted.

Verification
REQ-040 Inference, N_INPUTS=4, train_i=0, sum_sign_i=0:
- acc_clr_o is high in cycle 1;
- mac_en_o is high in cycles 2-6 with idx_o 0,1,2,3,4;
- done_o is high in cycle 8;
- y_o=1, err_cnt_o=0.
REQ-041 Training miss, train_i=1, target_i=1, sum_sign_i=1:
- wt_we_o is high in cycles 8-12 with idx_o 0..4 and upd_dir_o=1;
- done_o is high in cycle 13;
- y_o=0, err_cnt_o=1.
REQ-042 Training hit, train_i=1, target_i=0, sum_sign_i=1: no wt_we_o, done_o in cycle 8, err_cnt_o unchanged.
REQ-043 Busy rejection: start_i pulsed in cycles 3 and 8 of a pass -> exactly one done_o; busy_o low in cycle 9.
REQ-044 Mid-pass reset: reset_ni=0 during cycle 10 of a training pass -> all outputs 0 at once, no done_o; a new start after release completes normally.
REQ-045 Counter:
- with CNT_W=2, four misclassifying passes -> err_cnt_o 1,2,3,3 (saturated);
- clr_cnt_i asserted on the increment cycle -> err_cnt_o=0.
